// File: rtl/counter_pkg.sv
// Shared definitions for the parametrised up/down counter family:
// direction and boundary-mode encodings plus the load-value clamp.
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  // Load values above the top of the count range are pinned to it.
  function automatic int unsigned clamp_load(input int unsigned val,
                                             input int unsigned max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Enable prescaler: emits one tick every PRESCALE enabled cycles and
// holds its phase while en is low.
module tick_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  import counter_pkg::*;

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] r_pre;
  logic          w_last;

  assign w_last = (r_pre == PW'(PRESCALE - 1));
  assign tick   = en && w_last;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_pre <= '0;
    end else if (en) begin
      r_pre <= w_last ? '0 : r_pre + PW'(1);
    end
  end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with load, clear, wrap/saturate boundaries,
// enable prescaler, registered terminal-count pulse and sticky overflow.
module updown_counter_param #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_VAL  = 2**WIDTH - 1,
  parameter int unsigned SATURATE = 0,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);
  import counter_pkg::*;

  if (64'(MAX_VAL) >= (64'd1 << WIDTH)) begin : g_bad_max
    $error("updown_counter_param: MAX_VAL must be below 2**WIDTH");
  end
  if (PRESCALE < 1) begin : g_bad_pre
    $error("updown_counter_param: PRESCALE must be at least 1");
  end

  localparam logic [WIDTH-1:0] TOP  = WIDTH'(MAX_VAL);
  localparam mode_e            MODE = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_ovf;
  logic [WIDTH-1:0] w_next;
  logic             w_tick;
  logic             w_step;
  logic             w_bound;
  dir_e             w_dir;

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_pre (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .clr  (clear || load),
    .tick (w_tick)
  );

  assign w_dir  = dir_e'(up_dn);
  // clear/load take the whole cycle: the prescaler tick is swallowed.
  assign w_step = w_tick && !clear && !load;
  assign w_bound = w_step && (((w_dir == DIR_UP) && (r_count == TOP)) ||
                              ((w_dir == DIR_DOWN) && (r_count == '0)));

  always_comb begin
    w_next = r_count;
    if (clear) begin
      w_next = '0;
    end else if (load) begin
      w_next = WIDTH'(clamp_load(32'(load_val), MAX_VAL));
    end else if (w_step) begin
      if (w_dir == DIR_UP) begin
        if (r_count == TOP) w_next = (MODE == MODE_SAT) ? TOP : '0;
        else                w_next = r_count + WIDTH'(1);
      end else begin
        if (r_count == '0)  w_next = (MODE == MODE_SAT) ? '0 : TOP;
        else                w_next = r_count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_next;
      r_tc    <= w_bound;
      r_ovf   <= w_bound || (r_ovf && !ovf_clr);
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign ovf   = r_ovf;

endmodule
